masked_sbox_serial: RTL and testbench

- Sequential masked SubBytes engine for the AES-128 datapath.
- Accepts a full 128-bit shared state and streams its 16 bytes, one per cycle, through one masked_4stage_bv8_inv instance, which this block instantiates.
- Applies the input basis change before the inverter, and the output basis change plus the AES affine map after it.
- Reassembles the substituted shared state and hands it to the round logic with a start/done handshake.

---
 rtl/aes128_package.sv | 43 ++++
 rtl/masked_4stage_bv8_inv.sv | 93 +++++++++
 rtl/masked_sbox_serial.sv | 124 ++++++++++++
 tb/tb_masked_sbox_serial.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_package.sv
// rtl/aes128_package.sv - GF(2^8) helpers and basis matrices for the masked S-box datapath
package aes128_package;

    // Row i selects the input bits whose parity forms output bit i.
    typedef logic [7:0][7:0] bv8_matrix_t;

    // The inverter works directly in the AES polynomial basis, so the input map is the identity
    // and the output map folds in the linear part of the AES affine transform.
    localparam bv8_matrix_t IN_BASIS  = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    localparam bv8_matrix_t OUT_BASIS = {8'hF8, 8'h7C, 8'h3E, 8'h1F, 8'h8F, 8'hC7, 8'hE3, 8'hF1};
    localparam logic [7:0]  AFFINE_CONST = 8'h63;

    function automatic int num_4stage_inv_random(input int num_shares);
        return 16 * num_shares * (num_shares - 1);
    endfunction

    function automatic logic [7:0] bv8_mat_mul(input bv8_matrix_t m, input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) begin
            y[i] = ^(m[i] & x);
        end
        return y;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_sq(input logic [7:0] a);
        return gf_mul(a, a);
    endfunction

endpackage

// File: rtl/masked_4stage_bv8_inv.sv
// rtl/masked_4stage_bv8_inv.sv - four-stage masked GF(2^8) inverter (x^254 via four DOM multiplications)
module masked_4stage_bv8_inv
    import aes128_package::*;
#(
    parameter int  NUM_SHARES = 2,
    localparam int NUM_RANDOM = num_4stage_inv_random(NUM_SHARES)
) (
    input  logic                         in_clock,
    input  logic                         in_reset,
    input  logic [NUM_SHARES-1:0][7:0]   in_a,
    input  logic [NUM_RANDOM-1:0]        in_random,
    output logic [NUM_SHARES-1:0][7:0]   out_b
);

    localparam int NUM_PAIRS   = NUM_SHARES * (NUM_SHARES - 1) / 2;
    localparam int RND_PER_MUL = 8 * NUM_PAIRS;

    typedef logic [NUM_SHARES-1:0][7:0]                 shares_t;
    typedef logic [NUM_SHARES-1:0][NUM_SHARES-1:0][7:0] cross_t;

    function automatic int pair_index(input int i, input int j);
        return i * (2 * NUM_SHARES - i - 1) / 2 + (j - i - 1);
    endfunction

    // Cross products are refreshed with a shared random byte per share pair before being registered;
    // only the next stage compresses them back into NUM_SHARES shares.
    function automatic cross_t dom_cross(input shares_t a, input shares_t b,
                                         input logic [RND_PER_MUL-1:0] r);
        cross_t c;
        for (int i = 0; i < NUM_SHARES; i++) begin
            for (int j = 0; j < NUM_SHARES; j++) begin
                c[i][j] = gf_mul(a[i], b[j]);
                if (i < j) begin
                    c[i][j] = c[i][j] ^ r[8*pair_index(i, j) +: 8];
                end else if (i > j) begin
                    c[i][j] = c[i][j] ^ r[8*pair_index(j, i) +: 8];
                end
            end
        end
        return c;
    endfunction

    function automatic shares_t compress(input cross_t c);
        shares_t s;
        for (int i = 0; i < NUM_SHARES; i++) begin
            s[i] = '0;
            for (int j = 0; j < NUM_SHARES; j++) begin
                s[i] = s[i] ^ c[i][j];
            end
        end
        return s;
    endfunction

    cross_t  s1_c, s2_c, s3_c, s4_c;
    shares_t s1_x2, s2_x2, s3_x2, s2_a12;
    shares_t x2, a3, a12, a15, a240, a252;

    // Exponent chain: x^3 = x*x^2, x^15 = x^3*x^12, x^252 = x^240*x^12, x^254 = x^252*x^2.
    always_comb begin
        a3   = compress(s1_c);
        a15  = compress(s2_c);
        a252 = compress(s3_c);
        out_b = compress(s4_c);
        for (int i = 0; i < NUM_SHARES; i++) begin
            x2[i]   = gf_sq(in_a[i]);
            a12[i]  = gf_sq(gf_sq(a3[i]));
            a240[i] = gf_sq(gf_sq(gf_sq(gf_sq(a15[i]))));
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            s1_c   <= '0;
            s2_c   <= '0;
            s3_c   <= '0;
            s4_c   <= '0;
            s1_x2  <= '0;
            s2_x2  <= '0;
            s3_x2  <= '0;
            s2_a12 <= '0;
        end else begin
            s1_c   <= dom_cross(in_a, x2,      in_random[0*RND_PER_MUL +: RND_PER_MUL]);
            s1_x2  <= x2;
            s2_c   <= dom_cross(a3,   a12,     in_random[1*RND_PER_MUL +: RND_PER_MUL]);
            s2_a12 <= a12;
            s2_x2  <= s1_x2;
            s3_c   <= dom_cross(a240, s2_a12,  in_random[2*RND_PER_MUL +: RND_PER_MUL]);
            s3_x2  <= s2_x2;
            s4_c   <= dom_cross(a252, s3_x2,   in_random[3*RND_PER_MUL +: RND_PER_MUL]);
        end
    end

endmodule

// File: rtl/masked_sbox_serial.sv
// rtl/masked_sbox_serial.sv - byte-serial masked AES SubBytes over a shared 128-bit state
module masked_sbox_serial
    import aes128_package::*;
#(
    parameter int  NUM_SHARES = 2,
    localparam int NUM_RANDOM = num_4stage_inv_random(NUM_SHARES)
) (
    input  logic                          in_clock,
    input  logic                          in_reset,
    input  logic                          in_start,
    input  logic [NUM_SHARES-1:0][127:0]  in_state,
    input  logic [NUM_RANDOM-1:0]         in_random,
    output logic [NUM_SHARES-1:0][127:0]  out_state,
    output logic                          out_busy,
    output logic                          out_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

    state_t state, state_next;

    logic [NUM_SHARES-1:0][127:0] issue_sreg;
    // Only 15 bytes are buffered; the 16th goes straight from the datapath into out_state.
    logic [NUM_SHARES-1:0][119:0] collect_sreg;
    logic [3:0]                   issue_cnt;
    logic [3:0]                   collect_cnt;
    logic [3:0]                   valid_pipe;
    logic [NUM_SHARES-1:0][7:0]   inv_in, inv_out, sub_byte;
    logic                         accept, issuing, collecting, last_collect;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issuing    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_start) begin
                    accept     = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issuing = 1'b1;
                if (issue_cnt == 4'd15) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_collect) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign collecting   = valid_pipe[3];
    assign last_collect = collecting && (collect_cnt == 4'd15);
    assign out_busy     = (state != ST_IDLE);

    // Every operation here is share-local; share mixing happens only inside the inverter.
    always_comb begin
        for (int s = 0; s < NUM_SHARES; s++) begin
            inv_in[s]   = issuing ? bv8_mat_mul(IN_BASIS, issue_sreg[s][7:0]) : 8'h00;
            sub_byte[s] = bv8_mat_mul(OUT_BASIS, inv_out[s]) ^ ((s == 0) ? AFFINE_CONST : 8'h00);
        end
    end

    masked_4stage_bv8_inv #(
        .NUM_SHARES (NUM_SHARES)
    ) u_inv (
        .in_clock  (in_clock),
        .in_reset  (in_reset),
        .in_a      (inv_in),
        .in_random (in_random),
        .out_b     (inv_out)
    );

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state        <= ST_IDLE;
            issue_sreg   <= '0;
            collect_sreg <= '0;
            issue_cnt    <= '0;
            collect_cnt  <= '0;
            valid_pipe   <= '0;
            out_state    <= '0;
            out_done     <= 1'b0;
        end else begin
            state      <= state_next;
            out_done   <= last_collect;
            valid_pipe <= {valid_pipe[2:0], issuing};

            if (accept) begin
                issue_sreg  <= in_state;
                issue_cnt   <= '0;
                collect_cnt <= '0;
            end else if (issuing) begin
                for (int s = 0; s < NUM_SHARES; s++) begin
                    issue_sreg[s] <= {8'h00, issue_sreg[s][127:8]};
                end
                if (issue_cnt != 4'd15) begin
                    issue_cnt <= issue_cnt + 4'd1;
                end
            end

            if (collecting) begin
                for (int s = 0; s < NUM_SHARES; s++) begin
                    collect_sreg[s] <= {sub_byte[s], collect_sreg[s][119:8]};
                end
                if (collect_cnt != 4'd15) begin
                    collect_cnt <= collect_cnt + 4'd1;
                end
            end

            if (last_collect) begin
                for (int s = 0; s < NUM_SHARES; s++) begin
                    out_state[s] <= {sub_byte[s], collect_sreg[s]};
                end
            end
        end
    end

endmodule

// File: tb/tb_masked_sbox_serial.sv
// tb/tb_masked_sbox_serial.sv - self-checking bench for masked_sbox_serial
module tb_masked_sbox_serial;

    localparam int NUM_SHARES = 2;
    localparam int NUM_RANDOM = 32;

    logic                         in_clock;
    logic                         in_reset;
    logic                         in_start;
    logic [NUM_SHARES-1:0][127:0] in_state;
    logic [NUM_RANDOM-1:0]        in_random;
    logic [NUM_SHARES-1:0][127:0] out_state;
    logic                         out_busy;
    logic                         out_done;

    masked_sbox_serial #(
        .NUM_SHARES (NUM_SHARES)
    ) dut (
        .in_clock  (in_clock),
        .in_reset  (in_reset),
        .in_start  (in_start),
        .in_state  (in_state),
        .in_random (in_random),
        .out_state (out_state),
        .out_busy  (out_busy),
        .out_done  (out_done)
    );

    initial in_clock = 1'b0;
    always #5 in_clock = ~in_clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] sbox_tab [256];

    typedef struct {
        logic [127:0] plain;
        logic [127:0] mask;
        logic [127:0] exp_out;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    // Reference S-box: inverse from log/antilog tables over generator 0x03, then the affine map.
    task automatic build_sbox();
        logic [7:0] alog [255];
        int         lg   [256];
        logic [7:0] p;
        logic [7:0] inv;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            alog[i] = p;
            lg[p]   = i;
            p       = p ^ xtime(p);
        end
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : alog[(255 - lg[x]) % 255];
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] sbox_state(input logic [127:0] plain);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = sbox_tab[plain[8*k +: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge in_clock);
        #1;
        cyc++;
        in_random = $urandom();
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0b expected %0b", name, cyc, act, exp);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One job started in the current cycle S; returns in cycle S+21 with in_start low,
    // so a following call starts the next job back-to-back in S+21.
    task automatic do_job(input logic [127:0] plain, input logic [127:0] mask,
                          input logic [127:0] exp_out, input int poke_a, input int poke_b,
                          input logic [127:0] prev_exp, input bit chk_hold);
        in_start    = 1'b1;
        in_state[0] = plain ^ mask;
        in_state[1] = mask;
        for (int r = 1; r <= 21; r++) begin
            tick();
            chk1("busy", out_busy, (r <= 20));
            chk1("done", out_done, (r == 21));
            if (chk_hold && r <= 20) begin
                chk128("held_state", out_state[0] ^ out_state[1], prev_exp);
            end
            if (r == 21) begin
                chk128("result", out_state[0] ^ out_state[1], exp_out);
            end
            in_start = (r == poke_a) || (r == poke_b);
            if (in_start) begin
                in_state[0] = ~plain;
                in_state[1] = rand128();
            end else begin
                in_state[0] = plain ^ mask;
                in_state[1] = mask;
            end
        end
        in_start = 1'b0;
    endtask

    task automatic idle_watch(input int n, input string name, input logic [127:0] exp_state);
        for (int i = 0; i < n; i++) begin
            tick();
            chk1({name, "_busy"}, out_busy, 1'b0);
            chk1({name, "_done"}, out_done, 1'b0);
            chk128({name, "_state"}, out_state[0] ^ out_state[1], exp_state);
        end
    endtask

    initial begin
        logic [127:0] prev;
        logic [127:0] plain;
        logic [127:0] mask;
        logic [127:0] exp_v;

        build_sbox();

        vecs[0] = '{128'h0f0e0d0c0b0a09080706050403020100, 128'h0,
                    128'h76abd7fe2b670130c56f6bf27b777c63};
        vecs[1] = '{128'h1f1e1d1c1b1a19181716151413121110, 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5,
                    128'hc072a49cafa2d4adf04759fa7dc982ca};
        vecs[2] = '{{16{8'h53}}, 128'h0123456789abcdeffedcba9876543210, {16{8'hed}}};
        vecs[3] = '{128'h0, 128'h0, {16{8'h63}}};
        vecs[4] = '{128'h0f0e0d0c0b0a09080706050403020100, {16{8'hff}},
                    128'h76abd7fe2b670130c56f6bf27b777c63};

        in_reset  = 1'b1;
        in_start  = 1'b0;
        in_state  = '0;
        in_random = '0;
        tick();
        chk1("reset_busy", out_busy, 1'b0);
        chk1("reset_done", out_done, 1'b0);
        chk128("reset_state0", out_state[0], 128'h0);
        chk128("reset_state1", out_state[1], 128'h0);
        tick();
        in_reset = 1'b0;
        idle_watch(30, "idle", 128'h0);

        for (int i = 0; i < 5; i++) begin
            do_job(vecs[i].plain, vecs[i].mask, vecs[i].exp_out, -1, -1,
                   (i == 0) ? 128'h0 : vecs[i-1].exp_out, (i != 0));
        end
        idle_watch(3, "after_table", vecs[4].exp_out);

        // Start requests while busy must be dropped without queueing.
        do_job(vecs[1].plain, vecs[1].mask, vecs[1].exp_out, 5, 20, 128'h0, 1'b0);
        idle_watch(25, "no_requeue", vecs[1].exp_out);

        prev = vecs[1].exp_out;
        for (int i = 0; i < 100; i++) begin
            mask = rand128();
            do_job({16{8'h53}}, mask, {16{8'hed}}, -1, -1, prev, (i != 0));
            prev = {16{8'hed}};
        end
        for (int i = 0; i < 20; i++) begin
            plain = rand128();
            mask  = rand128();
            exp_v = sbox_state(plain);
            do_job(plain, mask, exp_v, -1, -1, prev, 1'b1);
            prev = exp_v;
        end
        idle_watch(2, "after_random", prev);

        // Reset in S+9 aborts the job and clears the previous result.
        in_start    = 1'b1;
        in_state[0] = vecs[1].plain ^ vecs[1].mask;
        in_state[1] = vecs[1].mask;
        for (int r = 1; r <= 9; r++) begin
            tick();
            in_start = 1'b0;
            chk1("pre_reset_busy", out_busy, 1'b1);
        end
        in_reset = 1'b1;
        tick();
        in_reset = 1'b0;
        chk1("abort_busy", out_busy, 1'b0);
        chk1("abort_done", out_done, 1'b0);
        chk128("abort_state0", out_state[0], 128'h0);
        chk128("abort_state1", out_state[1], 128'h0);
        idle_watch(25, "post_abort", 128'h0);
        do_job(vecs[0].plain, rand128(), vecs[0].exp_out, -1, -1, 128'h0, 1'b1);
        idle_watch(3, "final", vecs[0].exp_out);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
